// File: rtl/booth_mul_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
//   state_t        : control FSM states
//   digit_t        : recoded Booth digit selected by a 3-bit multiplier window
//   calc_w()       : internal extended operand width (XLEN+2 rounded up to even)
//   decode_digit() : maps a multiplier window to its Booth digit
package booth_mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        DIG_ZERO,
        DIG_P1,
        DIG_P2,
        DIG_N1,
        DIG_N2
    } digit_t;

    // Two extra bits let an unsigned XLEN operand be held as a positive
    // two's-complement value; the even width keeps the radix-4 windows aligned.
    function automatic int calc_w(input int xlen);
        return ((xlen + 3) / 2) * 2;
    endfunction

    function automatic digit_t decode_digit(input logic [2:0] win);
        digit_t dig;
        unique case (win)
            3'b001, 3'b010: dig = DIG_P1;
            3'b011:         dig = DIG_P2;
            3'b100:         dig = DIG_N2;
            3'b101, 3'b110: dig = DIG_N1;
            default:        dig = DIG_ZERO;  // 000 and 111
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_mul_iter_pp_sel.sv
// Radix-4 Booth partial-product selector (purely combinational).
//   i_window : multiplier bits [2:0] (current digit window incl. guard bit)
//   i_mcand  : sign-extended, already-shifted multiplicand
//   o_pp     : selected partial product (0, M, 2M, ~M or ~2M)
//   o_neg    : carry-in that completes the two's-complement negation
module booth_pp_sel
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 68
) (
    input  logic [2:0]       i_window,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [WIDTH-1:0] o_pp,
    output logic             o_neg
);

    digit_t w_digit;

    assign w_digit = decode_digit(i_window);

    // Negative digits emit the inverted magnitude and raise o_neg; the
    // accumulator adder absorbs the +1, so no separate negate stage exists.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        o_pp  = '0;
        o_neg = 1'b0;
        unique case (w_digit)
            DIG_P1: o_pp = i_mcand;
            DIG_P2: o_pp = {i_mcand[WIDTH-2:0], 1'b0};
            DIG_N1: begin
                o_pp  = ~i_mcand;
                o_neg = 1'b1;
            end
            DIG_N2: begin
                o_pp  = ~{i_mcand[WIDTH-2:0], 1'b0};
                o_neg = 1'b1;
            end
            default: o_pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier for the ALU multiply path.
// One Booth digit per cycle, early exit once the remaining multiplier
// digits are all zero, per-operand signedness (MUL/MULH/MULHSU/MULHU).
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready only in IDLE)
//   src1, src2            : multiplicand, multiplier (XLEN bits)
//   src1_signed/src2_signed : 1 = two's complement, 0 = unsigned
//   out_valid / out_ready : result handshake with full backpressure
//   result                : registered 2*XLEN-bit product
module booth_mul_iter
    import booth_mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    input  logic                src1_signed,
    input  logic                src2_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*XLEN-1:0]   result
);

    localparam int W      = calc_w(XLEN);
    localparam int W2     = 2 * W;
    localparam int N_ITER = W / 2;
    localparam int CNT_W  = $clog2(N_ITER + 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [W2-1:0]     r_mcand;
    logic [W2-1:0]     r_acc;
    logic [W:0]        r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_result;

    logic [W-1:0]      w_src1_ext;
    logic [W-1:0]      w_src2_ext;
    logic [W2-1:0]     w_pp;
    logic              w_neg;
    logic [W2-1:0]     w_acc_sum;
    logic [W:0]        w_mplier_shr;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_last;

    assign w_src1_ext = {{(W - XLEN){src1_signed & src1[XLEN-1]}}, src1};
    assign w_src2_ext = {{(W - XLEN){src2_signed & src2[XLEN-1]}}, src2};

    booth_pp_sel #(
        .WIDTH (W2)
    ) u_pp_sel (
        .i_window (r_mplier[2:0]),
        .i_mcand  (r_mcand),
        .o_pp     (w_pp),
        .o_neg    (w_neg)
    );

    assign w_acc_sum    = r_acc + w_pp + {{(W2 - 1){1'b0}}, w_neg};
    assign w_mplier_shr = {{2{r_mplier[W]}}, r_mplier[W:2]};
    assign w_cnt_inc    = r_cnt + CNT_W'(1);

    // Once the shifted multiplier is all 0s or all 1s every further window
    // is 000 or 111, i.e. a zero digit, so the product is already complete.
    assign w_last = (w_mplier_shr == '0) || (w_mplier_shr == '1) ||
                    (w_cnt_inc == CNT_W'(N_ITER));

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = S_BUSY;
            end
            S_BUSY: begin
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{W{w_src1_ext[W-1]}}, w_src1_ext};
                        r_mplier <= {w_src2_ext, 1'b0};
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_acc_sum;
                    r_mcand  <= {r_mcand[W2-3:0], 2'b00};
                    r_mplier <= w_mplier_shr;
                    r_cnt    <= w_cnt_inc;
                    // Capture straight from the final sum so the output
                    // port is always a register, never the adder.
                    if (w_last) r_result <= w_acc_sum[2*XLEN-1:0];
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_booth_mul_iter.sv
// Self-checking bench for booth_mul_iter (XLEN=32): directed vectors with
// hand-computed products, a scoreboard queue fed by the driver and a
// separate monitor that checks every presented result.
module tb_booth_mul_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        src1_signed;
    logic        src2_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    booth_mul_iter #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src1        (src1),
        .src2        (src2),
        .src1_signed (src1_signed),
        .src2_signed (src2_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          lat;      // expected accept->out_valid cycles, -1 = don't care
        int          acc_cyc;  // cycle in which the input handshake happened
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          seen  = 1'b0;
    logic [63:0] held;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s1, input logic s2);
        longint x;
        longint y;
        x = s1 ? longint'($signed(a)) : longint'({32'b0, a});
        y = s2 ? longint'($signed(b)) : longint'({32'b0, b});
        return 64'(x * y);
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got result=%h with nothing outstanding", result);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        held = result;
                        if (sb[0].lat >= 0)
                            check("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
                    end else begin
                        check("result_stable", result, held);
                    end
                    check("in_ready_low_in_done", 64'(in_ready), 64'd0);
                    if (out_ready) begin
                        check("result", result, sb[0].res);
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Driver helpers run in the phase #1 after a rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s1, input logic s2,
                         input logic [63:0] exp, input int lat);
        int tries = 0;
        in_valid    = 1'b1;
        src1        = a;
        src2        = b;
        src1_signed = s1;
        src2_signed = s2;
        while (!in_ready && tries < 200) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 after %0d cycles", tries);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{res: exp, lat: lat, acc_cyc: cyc});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s1;
        logic        s2;
        int          t;

        reset       = 1'b1;
        in_valid    = 1'b0;
        src1        = '0;
        src2        = '0;
        src1_signed = 1'b0;
        src2_signed = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result",    result,         64'd0);

        // Full-length, signed corners, mixed signedness, early termination.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 18);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, -1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, -1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001, -1);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 64'hC000_0000_8000_0000, -1);
        issue(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, -1);
        issue(32'd3,         32'd5,         1'b0, 1'b0, 64'd15, 3);
        issue(32'h1234_5678, 32'd0,         1'b0, 1'b0, 64'd0,  2);
        wait_drain();

        // Backpressure: result held while out_ready is low, in_valid ignored.
        out_ready = 1'b0;
        issue(32'd3, 32'd5, 1'b0, 1'b0, 64'd15, 3);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_out_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            src1     = 32'hDEAD_0000 + 32'(i);
            src2     = 32'h0000_BEEF;
            @(posedge clk); #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready",  64'(in_ready),  64'd0);
            check("bp_result",    result,         64'd15);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready",  64'(in_ready),  64'd1);
        issue(32'd100, 32'd200, 1'b0, 1'b0, 64'd20000, -1);
        wait_drain();

        // Reset during BUSY cycle 3 of a 17-iteration operation.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 18);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_result",    result,         64'd0);
        issue(32'd7, 32'd6, 1'b0, 1'b0, 64'd42, 3);
        wait_drain();

        // Random signed/unsigned pairs against the reference model.
        for (int i = 0; i < 1000; i++) begin
            a  = $urandom;
            b  = (i % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            s1 = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            issue(a, b, s1, s2, model(a, b, s1, s2), -1);
        end
        wait_drain();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
